alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves forwarded operands, decodes the ALU operation and
// holds the result in a single valid/ready pipeline register.
module alu_issue_stage #(
    parameter int n  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic          funct7b5,
    input  logic [4:0]    rs1_idx,
    input  logic [4:0]    rs2_idx,
    input  logic [4:0]    rd_idx,
    input  logic [n-1:0]  rs1_data,
    input  logic [n-1:0]  rs2_data,
    input  logic [n-1:0]  imm,
    input  logic          fwd1_en,
    input  logic [4:0]    fwd1_rd,
    input  logic [n-1:0]  fwd1_data,
    input  logic          fwd2_en,
    input  logic [4:0]    fwd2_rd,
    input  logic [n-1:0]  fwd2_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  inp1,
    output logic [n-1:0]  inp2,
    output logic [3:0]    aluop,
    output logic [4:0]    rd_out,
    output logic          illegal,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    logic [n-1:0] src1, src2;
    logic [n-1:0] d_inp1, d_inp2;
    logic [3:0]   d_aluop;
    logic [4:0]   d_rd;
    logic         d_ill;
    logic         load;

    // Youngest producer (EX/MEM) wins over MEM/WB; x0 is hardwired to zero.
    function automatic logic [n-1:0] resolve(
        input logic [4:0]   idx,
        input logic [n-1:0] rf,
        input logic         e1,
        input logic [4:0]   r1,
        input logic [n-1:0] d1,
        input logic         e2,
        input logic [4:0]   r2,
        input logic [n-1:0] d2
    );
        if (idx == 5'd0)              return '0;
        else if (e1 && (r1 == idx))   return d1;
        else if (e2 && (r2 == idx))   return d2;
        else                          return rf;
    endfunction

    assign src1 = resolve(rs1_idx, rs1_data, fwd1_en, fwd1_rd, fwd1_data,
                          fwd2_en, fwd2_rd, fwd2_data);
    assign src2 = resolve(rs2_idx, rs2_data, fwd1_en, fwd1_rd, fwd1_data,
                          fwd2_en, fwd2_rd, fwd2_data);

    always_comb begin
        d_aluop = ALU_ADD;
        d_inp1  = src1;
        d_inp2  = src2;
        d_rd    = rd_idx;
        d_ill   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000:  d_aluop = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b101:  d_aluop = funct7b5 ? ALU_SRA : ALU_SRL;
                    default: d_aluop = {1'b0, funct3};
                endcase
            end
            OPC_OP_IMM: begin
                d_inp2 = imm;
                case (funct3)
                    3'b101:  d_aluop = funct7b5 ? ALU_SRA : ALU_SRL;
                    default: d_aluop = {1'b0, funct3};
                endcase
            end
            OPC_LOAD: d_inp2 = imm;
            OPC_STORE: begin
                d_inp2 = imm;
                d_rd   = 5'd0;
            end
            OPC_BRANCH: begin
                d_rd = 5'd0;
                case (funct3)
                    3'b000, 3'b001: d_aluop = ALU_SUB;
                    3'b100, 3'b101: d_aluop = ALU_SLT;
                    3'b110, 3'b111: d_aluop = ALU_SLTU;
                    default:        d_ill   = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase

        if (d_ill) begin
            d_aluop = ALU_ADD;
            d_inp1  = '0;
            d_inp2  = '0;
            d_rd    = 5'd0;
        end

        // Shifters only consume the low five bits as the shift amount.
        if ((d_aluop == ALU_SLL) || (d_aluop == ALU_SRL) || (d_aluop == ALU_SRA))
            d_inp2 = {{(n-5){1'b0}}, d_inp2[4:0]};
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            inp1      <= '0;
            inp2      <= '0;
            aluop     <= ALU_ADD;
            rd_out    <= 5'd0;
            illegal   <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (load)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (load) begin
                inp1    <= d_inp1;
                inp2    <= d_inp2;
                aluop   <= d_aluop;
                rd_out  <= d_rd;
                illegal <= d_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && (stall_cnt != {CW{1'b1}}))
            stall_cnt <= stall_cnt + CW'(1);
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random
// traffic compared against a behavioural model of the issue stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        fwd1_en, fwd2_en;
    logic [4:0]  fwd1_rd, fwd2_rd;
    logic [31:0] fwd1_data, fwd2_data;

    logic        in_ready, out_valid, illegal;
    logic [31:0] inp1, inp2;
    logic [3:0]  aluop;
    logic [4:0]  rd_out;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] inp1_2, inp2_2;
    logic [3:0]  aluop2;
    logic [4:0]  rd_out2;
    logic [1:0]  stall_cnt2;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    logic        m_valid;
    logic [31:0] m_inp1, m_inp2;
    logic [3:0]  m_aluop;
    logic [4:0]  m_rd;
    logic        m_ill;
    int          m_stall;

    always #5 clk = ~clk;

    alu_issue_stage #(.n(32), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .fwd1_en(fwd1_en), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_en(fwd2_en), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .inp1(inp1), .inp2(inp2), .aluop(aluop), .rd_out(rd_out),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    alu_issue_stage #(.n(32), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .fwd1_en(fwd1_en), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_en(fwd2_en), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .inp1(inp1_2), .inp2(inp2_2), .aluop(aluop2), .rd_out(rd_out2),
        .illegal(illegal2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (fwd2_en && fwd2_rd == idx) v = fwd2_data;
        if (fwd1_en && fwd1_rd == idx) v = fwd1_data;
        if (idx == 0) v = 0;
        return v;
    endfunction

    // Operation codes: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 13 sra
    task automatic ref_decode();
        int op;
        logic [31:0] a, b;
        bit ill, writes;
        a = operand(rs1_idx, rs1_data);
        b = operand(rs2_idx, rs2_data);
        op = 0; ill = 0; writes = 0;
        if (opcode == 7'h33 || opcode == 7'h13) begin
            writes = 1;
            if (opcode == 7'h13) b = imm;
            op = int'(funct3);
            if (funct3 == 5 && funct7b5) op = 13;
            if (funct3 == 0 && funct7b5 && opcode == 7'h33) op = 8;
        end else if (opcode == 7'h03 || opcode == 7'h23) begin
            writes = (opcode == 7'h03);
            b = imm;
        end else if (opcode == 7'h63) begin
            if (funct3 <= 1) op = 8;
            else if (funct3 >= 4) op = (funct3 >= 6) ? 3 : 2;
            else ill = 1;
        end else begin
            ill = 1;
        end
        if (ill) begin
            a = 0; b = 0; op = 0; writes = 0;
        end
        if (op == 1 || op == 5 || op == 13) b = b % 32;
        m_inp1  = a;
        m_inp2  = b;
        m_aluop = 4'(op);
        m_rd    = writes ? rd_idx : 5'd0;
        m_ill   = ill;
    endtask

    task automatic model_reset();
        m_valid = 0; m_inp1 = 0; m_inp2 = 0; m_aluop = 0; m_rd = 0; m_ill = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("inp1", 64'(inp1), 64'(m_inp1));
        chk("inp2", 64'(inp2), 64'(m_inp2));
        chk("aluop", 64'(aluop), 64'(m_aluop));
        chk("rd_out", 64'(rd_out), 64'(m_rd));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall > 65535 ? 65535 : m_stall));
        chk("out_valid_cw2", 64'(out_valid2), 64'(m_valid));
        chk("inp1_cw2", 64'(inp1_2), 64'(m_inp1));
        chk("inp2_cw2", 64'(inp2_2), 64'(m_inp2));
        chk("aluop_cw2", 64'(aluop2), 64'(m_aluop));
        chk("rd_out_cw2", 64'(rd_out2), 64'(m_rd));
        chk("illegal_cw2", 64'(illegal2), 64'(m_ill));
        chk("stall_cnt_cw2", 64'(stall_cnt2), 64'(m_stall > 3 ? 3 : m_stall));
    endtask

    // Inputs must already be driven (at a negedge); returns at the next negedge.
    task automatic step();
        bit rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("in_ready_cw2", 64'(in_ready2), 64'(!m_valid || out_ready));
        @(posedge clk);
        rdy = !m_valid || out_ready;
        if (in_valid && !rdy) m_stall++;
        if (flush) m_valid = 0;
        else if (in_valid && rdy) begin
            ref_decode();
            m_valid = 1;
        end else if (out_ready) m_valid = 0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        in_valid = 0; out_ready = 1; flush = 0;
        opcode = 0; funct3 = 0; funct7b5 = 0;
        rs1_idx = 0; rs2_idx = 0; rd_idx = 0;
        rs1_data = 0; rs2_data = 0; imm = 0;
        fwd1_en = 0; fwd1_rd = 0; fwd1_data = 0;
        fwd2_en = 0; fwd2_rd = 0; fwd2_data = 0;
    endtask

    task automatic random_inputs();
        logic [6:0] opcs [6];
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
        opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'($urandom);
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 19) == 0);
        opcode    = opcs[$urandom_range(0, 5)];
        funct3    = 3'($urandom);
        funct7b5  = 1'($urandom);
        rs1_idx   = 5'($urandom_range(0, 7));
        rs2_idx   = 5'($urandom_range(0, 7));
        rd_idx    = 5'($urandom);
        rs1_data  = $urandom;
        rs2_data  = $urandom;
        imm       = $urandom;
        fwd1_en   = 1'($urandom);
        fwd1_rd   = 5'($urandom_range(0, 7));
        fwd1_data = $urandom;
        fwd2_en   = 1'($urandom);
        fwd2_rd   = 5'($urandom_range(0, 7));
        fwd2_data = $urandom;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        #12;
        check_outputs();
        chk("in_ready_rst", 64'(in_ready), 64'(1));

        @(negedge clk);
        rst_n = 1;

        // Register-register subtract
        in_valid = 1; opcode = 7'h33; funct3 = 0; funct7b5 = 1;
        rs1_idx = 1; rs1_data = 5; rs2_idx = 2; rs2_data = 3; rd_idx = 4;
        step();
        chk("sub_aluop", 64'(aluop), 64'(4'b1000));
        chk("sub_inp1", 64'(inp1), 64'(5));
        chk("sub_inp2", 64'(inp2), 64'(3));

        // Immediate arithmetic shift keeps only the shift amount
        opcode = 7'h13; funct3 = 3'b101; funct7b5 = 1; imm = 32'h0000_0423;
        step();
        chk("srai_aluop", 64'(aluop), 64'(4'b1101));
        chk("srai_inp2", 64'(inp2), 64'(32'h3));

        // Forwarding priority and x0
        opcode = 7'h33; funct3 = 0; funct7b5 = 0;
        rs1_idx = 7; rs1_data = 32'h11;
        fwd1_en = 1; fwd1_rd = 7; fwd1_data = 32'hAA;
        fwd2_en = 1; fwd2_rd = 7; fwd2_data = 32'hBB;
        step();
        chk("fwd_prio", 64'(inp1), 64'(32'hAA));
        rs1_idx = 0; fwd1_rd = 0;
        step();
        chk("fwd_x0", 64'(inp1), 64'(0));
        fwd1_en = 0; fwd2_en = 0;

        // Downstream stall for three cycles
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rs1_idx = 5'(i + 1); rs1_data = 32'(100 + i);
            step();
        end
        chk("stall3", 64'(stall_cnt), 64'(3));
        chk("stall3_inp1", 64'(inp1), 64'(0));
        out_ready = 1;
        step();
        chk("after_stall_inp1", 64'(inp1), 64'(102));

        // Flush beats a simultaneous transfer, then an illegal opcode
        flush = 1;
        step();
        chk("flush_valid", 64'(out_valid), 64'(0));
        flush = 0; opcode = 7'h7F; rd_idx = 9;
        step();
        chk("ill_flag", 64'(illegal), 64'(1));
        chk("ill_aluop", 64'(aluop), 64'(0));
        chk("ill_rd", 64'(rd_out), 64'(0));

        // Five more stall cycles: narrow counter saturates
        out_ready = 0; opcode = 7'h03;
        for (int i = 0; i < 5; i++) step();
        chk("sat_cw2", 64'(stall_cnt2), 64'(3));

        // Reset mid-stall drops the held entry immediately
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1;
        out_ready = 1; opcode = 7'h23; rs1_idx = 3; rs1_data = 32'h40; imm = 32'h8;
        step();
        chk("first_after_rst", 64'(out_valid), 64'(1));

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
